// File: rtl/dmem_if_pkg.sv
// Shared types for the MEM-stage data-memory adapter: FSM encoding, access
// size codes and the alignment rule.
package dmem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Size code 2'b11 is handled like a word access.
  function automatic logic is_misaligned(input logic [1:0] offset,
                                         input logic [1:0] size);
    case (size)
      SZ_HALF: is_misaligned = offset[0];
      SZ_BYTE: is_misaligned = 1'b0;
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: moves right-aligned store data/strobes into bus lanes
// and right-aligns returning read data.
module dmem_lane_align
  import dmem_if_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  addr_lo_q,
  input  logic [1:0]  acc_size,
  input  logic [31:0] store_data,
  input  logic [3:0]  write_strb,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_wstrb,
  output logic [31:0] rdata_aligned,
  output logic        misaligned
);

  assign lane_wdata    = store_data << {addr_lo, 3'b000};
  assign lane_wstrb    = write_strb << addr_lo;
  // Read data uses the offset captured at issue, not the live address.
  assign rdata_aligned = rsp_rdata >> {addr_lo_q, 3'b000};
  assign misaligned    = is_misaligned(addr_lo, acc_size);

endmodule

// File: rtl/dmem_if.sv
// MEM-stage data-memory bus adapter: one valid/ready transaction per access,
// pipeline stall while in flight, misalignment and response-timeout pulses.
module dmem_if
  import dmem_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [1:0]  acc_size,
  input  logic [31:0] store_data,
  input  logic [3:0]  write_strb,
  output logic [31:0] mem_data,
  output logic        stall,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  // Handshake: the request is presented with req_valid and every req_* field
  // held constant until a cycle where req_valid & req_ready are both high;
  // read data is accepted only while waiting in RESP on rsp_valid.

  state_t      state_q;
  logic [1:0]  addr_lo_q;
  logic        is_load_q;
  logic [7:0]  cnt;
  logic        access;
  logic        misaligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] rdata_aligned;

  assign access    = rd_en | wr_en;
  assign dbg_state = state_q;

  dmem_lane_align u_align (
    .addr_lo       (addr[1:0]),
    .addr_lo_q     (addr_lo_q),
    .acc_size      (acc_size),
    .store_data    (store_data),
    .write_strb    (write_strb),
    .rsp_rdata     (rsp_rdata),
    .lane_wdata    (lane_wdata),
    .lane_wstrb    (lane_wstrb),
    .rdata_aligned (rdata_aligned),
    .misaligned    (misaligned)
  );

  // DONE deliberately drops stall for one cycle so the pipeline advances.
  assign stall = ((state_q == IDLE) && access && !misaligned) ||
                 (state_q == REQ) || (state_q == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_lo_q    <= 2'b00;
      is_load_q    <= 1'b0;
      cnt          <= 8'd0;
      mem_data     <= 32'd0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      req_valid    <= 1'b0;
      req_we       <= 1'b0;
      req_addr     <= 32'd0;
      req_wdata    <= 32'd0;
      req_wstrb    <= 4'd0;
    end else begin
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              misalign_exc <= 1'b1;
            end else begin
              req_valid <= 1'b1;
              req_we    <= wr_en;
              req_addr  <= {addr[31:2], 2'b00};
              req_wdata <= wr_en ? lane_wdata : 32'd0;
              req_wstrb <= wr_en ? lane_wstrb : 4'd0;
              addr_lo_q <= addr[1:0];
              is_load_q <= rd_en;
              state_q   <= REQ;
            end
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            cnt       <= 8'd0;
            state_q   <= is_load_q ? RESP : DONE;
          end
        end
        RESP: begin
          if (rsp_valid) begin
            mem_data <= rdata_aligned;
            state_q  <= DONE;
          end else if (cnt == TO_LAST) begin
            bus_err  <= 1'b1;
            mem_data <= 32'd0;
            state_q  <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_if.sv
// Directed bench for dmem_if: drives LSU requests and plays the bus slave
// cycle by cycle, comparing against hand-computed expectations.
module tb_dmem_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [1:0]  acc_size = 2'b00;
  logic [31:0] store_data = 32'd0;
  logic [3:0]  write_strb = 4'd0;
  logic [31:0] mem_data;
  logic        stall;
  logic        misalign_exc;
  logic        bus_err;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_rdata = 32'd0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Results of the most recent do_access call.
  int          n_stall, n_mis, n_err, n_rv;
  logic [31:0] f_addr, f_wdata;
  logic [3:0]  f_wstrb;
  logic        f_we, f_stable;

  dmem_if #(.TIMEOUT_CYC(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .addr         (addr),
    .acc_size     (acc_size),
    .store_data   (store_data),
    .write_strb   (write_strb),
    .mem_data     (mem_data),
    .stall        (stall),
    .misalign_exc (misalign_exc),
    .bus_err      (bus_err),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // Presents one access in cycle 0 (inputs scrambled afterwards), then acts as
  // the slave: ready after ready_wait REQ cycles, rsp_valid rsp_wait cycles
  // after the cycle following the handshake (rsp_wait < 0: never).
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [1:0] sz, input logic [31:0] d,
                           input logic [3:0] strb, input int ready_wait,
                           input int rsp_wait, input logic [31:0] rdata,
                           input int ncyc);
    int hs_cyc;
    hs_cyc = -1;
    n_stall = 0; n_mis = 0; n_err = 0; n_rv = 0;
    f_addr = '0; f_wdata = '0; f_wstrb = '0; f_we = 1'b0; f_stable = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rd_en      = (c == 0) ? rd : 1'b0;
      wr_en      = (c == 0) ? wr : 1'b0;
      addr       = (c == 0) ? a : 32'hFFFF_FFFF;
      acc_size   = (c == 0) ? sz : 2'b11;
      store_data = (c == 0) ? d : 32'hDEAD_BEEF;
      write_strb = (c == 0) ? strb : 4'hF;
      req_ready  = req_valid && (n_rv >= ready_wait);
      rsp_valid  = (hs_cyc >= 0) && (rsp_wait >= 0) && (c == hs_cyc + 1 + rsp_wait);
      rsp_rdata  = rsp_valid ? rdata : 32'h5A5A_5A5A;
      #1;
      if (stall) n_stall++;
      if (misalign_exc) n_mis++;
      if (bus_err) n_err++;
      if (req_valid) begin
        if (n_rv == 0) begin
          f_addr = req_addr; f_wdata = req_wdata; f_wstrb = req_wstrb; f_we = req_we;
        end else if (req_addr !== f_addr || req_wdata !== f_wdata ||
                     req_wstrb !== f_wstrb || req_we !== f_we) begin
          f_stable = 1'b0;
        end
        n_rv++;
      end
      if (req_valid && req_ready) hs_cyc = c;
    end
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_data, stall, misalign_exc, bus_err, req_valid, req_we, req_addr,
         req_wdata, req_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got mem=%h stall=%b rv=%b addr=%h wdata=%h wstrb=%b, required all zero",
               mem_data, stall, req_valid, req_addr, req_wdata, req_wstrb);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store_byte();
    do_access(1'b0, 1'b1, 32'h0000_1003, 2'b10, 32'h0000_00AB, 4'b0001, 0, -1, 32'd0, 3);
    checks++;
    if (f_addr !== 32'h0000_1000) begin
      errors++; $display("FAIL sb_addr: got %h required 00001000", f_addr);
    end
    checks++;
    if (f_wstrb !== 4'b1000) begin
      errors++; $display("FAIL sb_wstrb: got %b required 1000", f_wstrb);
    end
    checks++;
    if (f_wdata !== 32'hAB00_0000) begin
      errors++; $display("FAIL sb_wdata: got %h required ab000000", f_wdata);
    end
    checks++;
    if (f_we !== 1'b1) begin
      errors++; $display("FAIL sb_we: got %b required 1", f_we);
    end
    checks++;
    if (n_stall != 2) begin
      errors++; $display("FAIL sb_stall: got %0d required 2", n_stall);
    end
  endtask

  task automatic test_store_half();
    do_access(1'b0, 1'b1, 32'h0000_6002, 2'b01, 32'h0000_1234, 4'b0011, 0, -1, 32'd0, 3);
    checks++;
    if (f_wstrb !== 4'b1100 || f_wdata !== 32'h1234_0000) begin
      errors++; $display("FAIL sh_lanes: got wstrb=%b wdata=%h required 1100/12340000", f_wstrb, f_wdata);
    end
  endtask

  task automatic test_load_half();
    do_access(1'b1, 1'b0, 32'h0000_2002, 2'b01, 32'd0, 4'b0000, 0, 0, 32'hBEEF_1234, 4);
    checks++;
    if (mem_data !== 32'h0000_BEEF) begin
      errors++; $display("FAIL lh_data: got %h required 0000beef", mem_data);
    end
    checks++;
    if (n_stall != 3) begin
      errors++; $display("FAIL lh_stall: got %0d required 3", n_stall);
    end
    checks++;
    if (f_wstrb !== 4'b0000 || f_we !== 1'b0 || f_addr !== 32'h0000_2000) begin
      errors++; $display("FAIL lh_req: got wstrb=%b we=%b addr=%h required 0000/0/00002000", f_wstrb, f_we, f_addr);
    end
  endtask

  task automatic test_load_byte();
    do_access(1'b1, 1'b0, 32'h0000_2101, 2'b10, 32'd0, 4'b0000, 1, 1, 32'hAABB_CCDD, 6);
    checks++;
    if (mem_data !== 32'h00AA_BBCC) begin
      errors++; $display("FAIL lb_data: got %h required 00aabbcc", mem_data);
    end
    checks++;
    if (n_stall != 5) begin
      errors++; $display("FAIL lb_stall: got %0d required 5", n_stall);
    end
  endtask

  task automatic test_misalign();
    do_access(1'b1, 1'b0, 32'h0000_3001, 2'b00, 32'd0, 4'b0000, 0, 0, 32'd0, 3);
    checks++;
    if (n_mis != 1) begin
      errors++; $display("FAIL mis_pulse: got %0d pulses required 1", n_mis);
    end
    checks++;
    if (n_rv != 0 || n_stall != 0) begin
      errors++; $display("FAIL mis_noreq: got req_valid cycles=%0d stall=%0d required 0/0", n_rv, n_stall);
    end
    // size 11 behaves as word: offset 2 is misaligned
    do_access(1'b0, 1'b1, 32'h0000_3002, 2'b11, 32'd1, 4'b1111, 0, 0, 32'd0, 3);
    checks++;
    if (n_mis != 1 || n_rv != 0) begin
      errors++; $display("FAIL mis_size3: got pulses=%0d rv=%0d required 1/0", n_mis, n_rv);
    end
    // half at offset 2 is aligned
    do_access(1'b0, 1'b1, 32'h0000_3002, 2'b01, 32'd1, 4'b0011, 0, 0, 32'd0, 3);
    checks++;
    if (n_mis != 0 || n_stall != 2) begin
      errors++; $display("FAIL half_ok: got pulses=%0d stall=%0d required 0/2", n_mis, n_stall);
    end
  endtask

  task automatic test_ready_delay();
    do_access(1'b0, 1'b1, 32'h0000_4000, 2'b00, 32'h1357_9BDF, 4'b1111, 3, -1, 32'd0, 6);
    checks++;
    if (n_stall != 5) begin
      errors++; $display("FAIL rd_stall: got %0d required 5", n_stall);
    end
    checks++;
    if (f_stable !== 1'b1 || n_rv != 4) begin
      errors++; $display("FAIL rd_stable: got stable=%b rv_cycles=%0d required 1/4", f_stable, n_rv);
    end
    checks++;
    if (f_wdata !== 32'h1357_9BDF || f_wstrb !== 4'b1111 || f_addr !== 32'h0000_4000) begin
      errors++; $display("FAIL rd_fields: got %h/%b/%h required 13579bdf/1111/00004000", f_wdata, f_wstrb, f_addr);
    end
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, 32'h0000_4800, 2'b00, 32'd0, 4'b0000, 0, -1, 32'd0, 7);
    checks++;
    if (n_err != 1) begin
      errors++; $display("FAIL to_pulse: got %0d bus_err pulses required 1", n_err);
    end
    checks++;
    if (n_stall != 6) begin
      errors++; $display("FAIL to_stall: got %0d required 6", n_stall);
    end
    checks++;
    if (mem_data !== 32'd0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL to_end: got mem=%h state=%0d required 0/0", mem_data, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 1'b1, 32'h0000_8000, 2'b00, 32'hCAFE_F00D, 4'b1111, 0, -1, 32'd0, 3);
    checks++;
    if (n_stall != 2 || f_wdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL b2b_store: got stall=%0d wdata=%h required 2/cafef00d", n_stall, f_wdata);
    end
    do_access(1'b1, 1'b0, 32'h0000_8000, 2'b00, 32'd0, 4'b0000, 0, 0, 32'h0BAD_F00D, 4);
    checks++;
    if (n_stall != 3 || mem_data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL b2b_load: got stall=%0d mem=%h required 3/0badf00d", n_stall, mem_data);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rd_en = 1'b1; addr = 32'h0000_7000; acc_size = 2'b00;
    @(negedge clk);
    rd_en = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    #1;
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++; $display("FAIL rm_inresp: got state %0d required 2", dbg_state);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b0 || stall !== 1'b0 || dbg_state !== 2'd0 || mem_data !== 32'd0) begin
      errors++; $display("FAIL rm_abort: got rv=%b stall=%b state=%0d mem=%h required 0/0/0/0",
                         req_valid, stall, dbg_state, mem_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_access(1'b1, 1'b0, 32'h0000_5000, 2'b00, 32'd0, 4'b0000, 0, 0, 32'h1122_3344, 4);
    checks++;
    if (mem_data !== 32'h1122_3344 || n_stall != 3) begin
      errors++; $display("FAIL rm_after: got mem=%h stall=%0d required 11223344/3", mem_data, n_stall);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_half();
    test_load_half();
    test_load_byte();
    test_misalign();
    test_ready_delay();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
